// File: rtl/bram_rr_arbiter_pkg.sv
// Shared definitions for the two-client BRAM arbiter: client encoding and
// the saturating conflict-counter helper.
package bram_rr_arbiter_pkg;

    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;
    localparam int   CNT_W    = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic             inc);
        if (inc && (cnt != {CNT_W{1'b1}}))
            return cnt + 1'b1;
        return cnt;
    endfunction

endpackage

// File: rtl/bram_rr_arbiter_arb2.sv
// Two-way round-robin arbiter with a registered pointer. The grant is
// combinational; the pointer moves to the loser after every grant.
module rr_arb2
    import bram_rr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       owner
);

    logic ptr;

    always_comb begin
        owner = CLIENT_A;
        gnt   = 2'b00;
        if (req == 2'b11)
            owner = ptr;
        else if (req[1])
            owner = CLIENT_B;
        // Held-in-reset arbiters must not grant, so the BRAM sees no strobes.
        if (!rst && (req != 2'b00))
            gnt = (owner == CLIENT_B) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= CLIENT_A;
        else if (gnt != 2'b00)
            ptr <= ~owner;
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Shares a simple dual-port BRAM between clients A and B. Write and read
// ports are arbitrated independently, so a write and a read can overlap.
module bram_rr_arbiter
    import bram_rr_arbiter_pkg::*;
#(
    parameter int N_ADDR     = 256,
    parameter int DATA_WIDTH = 16,
    localparam int AW        = $clog2(N_ADDR)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [AW-1:0]         a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_gnt,
    output logic                  a_dvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [AW-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic                  b_gnt,
    output logic                  b_dvalid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  bram_wen,
    output logic [AW-1:0]         bram_wadd,
    output logic [DATA_WIDTH-1:0] bram_win,
    output logic                  bram_ren,
    output logic [AW-1:0]         bram_radd,
    input  logic [DATA_WIDTH-1:0] bram_wout,
    output logic [CNT_W-1:0]      wr_conflicts,
    output logic [CNT_W-1:0]      rd_conflicts
);

    logic [1:0] wr_req, rd_req, wr_gnt, rd_gnt;
    logic       wr_owner, rd_owner;

    assign wr_req = {b_req &  b_we, a_req &  a_we};
    assign rd_req = {b_req & ~b_we, a_req & ~a_we};

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (wr_req),
        .gnt   (wr_gnt),
        .owner (wr_owner)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (rd_req),
        .gnt   (rd_gnt),
        .owner (rd_owner)
    );

    assign a_gnt = wr_gnt[0] | rd_gnt[0];
    assign b_gnt = wr_gnt[1] | rd_gnt[1];

    // Idle owner is A, so the muxes rest on client A's fields.
    assign bram_wen  = |wr_gnt;
    assign bram_ren  = |rd_gnt;
    assign bram_wadd = rst ? '0 : ((wr_owner == CLIENT_B) ? b_addr : a_addr);
    assign bram_win  = rst ? '0 : ((wr_owner == CLIENT_B) ? b_din  : a_din);
    assign bram_radd = rst ? '0 : ((rd_owner == CLIENT_B) ? b_addr : a_addr);

    assign rd_data = bram_wout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_dvalid     <= 1'b0;
            b_dvalid     <= 1'b0;
            wr_conflicts <= '0;
            rd_conflicts <= '0;
        end else begin
            a_dvalid     <= rd_gnt[0];
            b_dvalid     <= rd_gnt[1];
            wr_conflicts <= sat_inc(wr_conflicts, &wr_req);
            rd_conflicts <= sat_inc(rd_conflicts, &rd_req);
        end
    end

endmodule
